// File: rtl/vload_pkg.sv
// Shared types and constants for the vector-load gather stage.
//   vload_state_t : FSM encoding (IDLE, FETCH, DONE)
//   S/V/SIZE defaults : scalar width, vector width, ROM depth shared with the image ROM
//   calc_lanes / idx_width : derived lane count and lane-index width
package vload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } vload_state_t;

    localparam int S_DEFAULT    = 32;
    localparam int V_DEFAULT    = 192;
    localparam int SIZE_DEFAULT = 30015;

    function automatic int calc_lanes(input int s, input int v);
        return v / s;
    endfunction

    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vload_addr_gen.sv
// Lane index counter and running-sum address generator.
//   clk, reset     : clock, async active-high reset
//   load           : accept a new request (latch base/stride, idx=0)
//   advance        : FETCH cycle; step to the next lane unless on the last one
//   base_addr      : lane-0 word address
//   stride         : per-lane address increment
//   mem_addr       : current lane address (wraps modulo 2^S), holds outside FETCH
//   lane_idx       : current lane index
//   last_lane      : current lane is LANES-1
//   oob_hit        : current address is beyond the ROM
module vload_addr_gen
    import vload_pkg::*;
#(
    parameter int S     = S_DEFAULT,
    parameter int LANES = 6,
    parameter int SIZE  = SIZE_DEFAULT,
    parameter int IDX_W = idx_width(LANES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [S-1:0]     base_addr,
    input  logic [S-1:0]     stride,
    output logic [S-1:0]     mem_addr,
    output logic [IDX_W-1:0] lane_idx,
    output logic             last_lane,
    output logic             oob_hit
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [S-1:0]     addr_q, addr_d;
    logic [S-1:0]     stride_q, stride_d;

    always_comb begin
        idx_d    = idx_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            idx_d    = '0;
            addr_d   = base_addr;
            stride_d = stride;
        end else if (advance && !last_lane) begin
            idx_d  = idx_q + 1'b1;
            // Running sum replaces base + idx*stride; natural S-bit wrap.
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign mem_addr  = addr_q;
    assign lane_idx  = idx_q;
    assign last_lane = (idx_q == IDX_W'(LANES - 1));
    assign oob_hit   = (addr_q >= S'(SIZE));

endmodule

// File: rtl/vector_load_gather.sv
// Vector-load gather stage: fetches LANES strided words from the image ROM
// and packs them into one V-bit vector.
//   clk, reset : clock, async active-high reset
//   start      : request pulse, accepted only when not busy
//   base_addr  : lane-0 word address
//   stride     : address increment between lanes
//   mem_addr   : ROM address (combinational-read ROM)
//   mem_rd     : ROM data, only [S-1:0] used
//   vec_out    : gathered vector, lane i at [S*i +: S]
//   done       : one-cycle pulse, vec_out complete
//   busy       : FETCH in progress
//   oob        : some lane of the current request was out of bounds
//
// state | meaning
// IDLE  | waiting for start
// FETCH | one lane fetched per cycle
// DONE  | done pulse; start here chains straight into FETCH
module vector_load_gather
    import vload_pkg::*;
#(
    parameter int S    = S_DEFAULT,
    parameter int V    = V_DEFAULT,
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [S-1:0] base_addr,
    input  logic [S-1:0] stride,
    output logic [S-1:0] mem_addr,
    input  logic [V-1:0] mem_rd,
    output logic [V-1:0] vec_out,
    output logic         done,
    output logic         busy,
    output logic         oob
);

    localparam int LANES = calc_lanes(S, V);
    localparam int IDX_W = idx_width(LANES);

    vload_state_t     state_q, state_d;
    logic [V-1:0]     vec_q, vec_d;
    logic             oob_q, oob_d;
    logic             load;
    logic [IDX_W-1:0] lane_idx;
    logic             last_lane;
    logic             oob_hit;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^mem_rd[V-1:S];

    vload_addr_gen #(
        .S     (S),
        .LANES (LANES),
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (state_q == FETCH),
        .base_addr (base_addr),
        .stride    (stride),
        .mem_addr  (mem_addr),
        .lane_idx  (lane_idx),
        .last_lane (last_lane),
        .oob_hit   (oob_hit)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        oob_d   = oob_q;
        load    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    vec_d   = '0;
                    oob_d   = 1'b0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_idx == IDX_W'(i)) begin
                        vec_d[i*S +: S] = oob_hit ? '0 : mem_rd[S-1:0];
                    end
                end
                if (oob_hit) begin
                    oob_d = 1'b1;
                end
                if (last_lane) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            oob_q   <= oob_d;
        end
    end

    assign vec_out = vec_q;
    assign oob     = oob_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q == FETCH);

endmodule
